// File: rtl/vector_reverse_pipe.sv
// Per-word vector transform (pass / element reverse / intra-element reverse / full bit reverse)
// feeding a 2-entry output FIFO. Optional transfer counter under VECTOR_REVERSE_XFER_COUNT_EN.

module vector_reverse_lane #(
  parameter int ELEM = 1
) (
  input  logic [ELEM-1:0] elem_i,
  output logic [ELEM-1:0] elem_o
);
  for (genvar j = 0; j < ELEM; j++) begin : g_bit
    assign elem_o[j] = elem_i[ELEM-1-j];
  end
endmodule

module vector_reverse_pipe #(
  parameter int WIDTH = 8,
  parameter int ELEM  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vector,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_vector
`ifdef VECTOR_REVERSE_XFER_COUNT_EN
  ,
  output logic [15:0]      xfer_count
`endif
);
  localparam int N = WIDTH / ELEM;

  logic [N-1:0][ELEM-1:0] in_el, rev_elem, rev_intra;
  logic [WIDTH-1:0]       rev_full, xf_d;

  assign in_el = in_vector;

  for (genvar k = 0; k < N; k++) begin : g_lane
    assign rev_elem[k] = in_el[N-1-k];
    vector_reverse_lane #(.ELEM(ELEM)) u_lane (
      .elem_i (in_el[k]),
      .elem_o (rev_intra[k])
    );
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_full
    assign rev_full[i] = in_vector[WIDTH-1-i];
  end

  always_comb begin
    xf_d = in_vector;
    case (in_mode)
      2'b01:   xf_d = rev_elem;
      2'b10:   xf_d = rev_intra;
      2'b11:   xf_d = rev_full;
      default: xf_d = in_vector;
    endcase
  end

  // rdy_q keeps in_ready low during reset and through the release cycle.
  logic [1:0][WIDTH-1:0] mem_q;
  logic                  head_q, rdy_q;
  logic [1:0]            cnt_q, cnt_d;
  logic                  push, pop, tail;

  assign in_ready   = rdy_q && (cnt_q != 2'd2);
  assign out_valid  = (cnt_q != 2'd0);
  assign out_vector = mem_q[head_q];
  assign push       = in_valid && in_ready;
  assign pop        = out_valid && out_ready;
  assign tail       = head_q ^ cnt_q[0];

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q  <= '0;
      head_q <= 1'b0;
      cnt_q  <= 2'd0;
      rdy_q  <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (push) mem_q[tail] <= xf_d;
      if (pop)  head_q <= ~head_q;
      cnt_q <= cnt_d;
    end
  end

`ifdef VECTOR_REVERSE_XFER_COUNT_EN
  logic [15:0] xfer_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      xfer_q <= 16'd0;
    else if (pop) xfer_q <= xfer_q + 16'd1;
  end

  assign xfer_count = xfer_q;
`endif

endmodule

// File: tb/tb_vector_reverse_pipe.sv
// Bench for vector_reverse_pipe: two instances (ELEM=1 and ELEM=4, WIDTH=8) share stimulus;
// checked against constant vectors and a queue-based reference model.

module tb_vector_reverse_pipe;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, out_ready;
  logic [7:0] in_vector;
  logic [1:0] in_mode;
  logic       in_ready1, out_valid1, in_ready4, out_valid4;
  logic [7:0] out_vector1, out_vector4;
`ifdef VECTOR_REVERSE_XFER_COUNT_EN
  logic [15:0] xc1, xc4;
`endif

  int errors = 0;
  int checks = 0;
  logic mrdy = 1'b0;
  logic [7:0] q1[$];
  logic [7:0] q4[$];

  always #5 clk = ~clk;

  vector_reverse_pipe #(.WIDTH(8), .ELEM(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_vector(in_vector), .in_mode(in_mode), .out_valid(out_valid1),
    .out_ready(out_ready), .out_vector(out_vector1)
`ifdef VECTOR_REVERSE_XFER_COUNT_EN
    , .xfer_count(xc1)
`endif
  );

  vector_reverse_pipe #(.WIDTH(8), .ELEM(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .in_vector(in_vector), .in_mode(in_mode), .out_valid(out_valid4),
    .out_ready(out_ready), .out_vector(out_vector4)
`ifdef VECTOR_REVERSE_XFER_COUNT_EN
    , .xfer_count(xc4)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Output bit i takes its value from a source bit chosen by the mode rule.
  function automatic logic [7:0] model(input logic [7:0] x, input logic [1:0] m, input int e);
    logic [7:0] r;
    int n, k, j, src;
    n = 8 / e;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      k = i / e;
      j = i % e;
      case (m)
        2'd0:    src = i;
        2'd1:    src = (n - 1 - k) * e + j;
        2'd2:    src = k * e + (e - 1 - j);
        default: src = 7 - i;
      endcase
      r[i] = x[src];
    end
    return r;
  endfunction

  task automatic tick();
    logic pu, po;
    chk("in_ready1", 32'(in_ready1), 32'(mrdy && (q1.size() < 2)));
    chk("in_ready4", 32'(in_ready4), 32'(mrdy && (q4.size() < 2)));
    chk("out_valid1", 32'(out_valid1), 32'(q1.size() > 0));
    chk("out_valid4", 32'(out_valid4), 32'(q4.size() > 0));
    po = out_ready && (q1.size() > 0);
    pu = in_valid && mrdy && (q1.size() < 2);
    if (po) begin
      chk("out_vector1", 32'(out_vector1), 32'(q1[0]));
      chk("out_vector4", 32'(out_vector4), 32'(q4[0]));
      void'(q1.pop_front());
      void'(q4.pop_front());
    end
    if (pu) begin
      q1.push_back(model(in_vector, in_mode, 1));
      q4.push_back(model(in_vector, in_mode, 4));
    end
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [7:0] vec;
    logic [1:0] mode;
    logic [7:0] exp1;
    logic [7:0] exp4;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0] = '{8'h01, 2'd1, 8'h80, 8'h10};
    tbl[1] = '{8'h12, 2'd0, 8'h12, 8'h12};
    tbl[2] = '{8'h12, 2'd1, 8'h48, 8'h21};
    tbl[3] = '{8'h12, 2'd2, 8'h12, 8'h84};
    tbl[4] = '{8'h12, 2'd3, 8'h48, 8'h48};
    tbl[5] = '{8'hA5, 2'd1, 8'hA5, 8'h5A};
    tbl[6] = '{8'hA5, 2'd2, 8'hA5, 8'h5A};
    tbl[7] = '{8'h0F, 2'd1, 8'hF0, 8'hF0};
    tbl[8] = '{8'h0F, 2'd2, 8'h0F, 8'h0F};
    tbl[9] = '{8'h80, 2'd3, 8'h01, 8'h01};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_vector = '0; in_mode = '0;
    #2;
    chk("rst_out_valid", 32'(out_valid1), 32'd0);
    chk("rst_in_ready", 32'(in_ready1), 32'd0);
    chk("rst_out_vector", 32'(out_vector1), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_held_in_ready", 32'(in_ready4), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("release_in_ready", 32'(in_ready1), 32'd1);
    chk("release_out_valid", 32'(out_valid1), 32'd0);
    mrdy = 1'b1;

    // Directed transform table, one word at a time with latency check.
    out_ready = 1'b1;
    for (int t = 0; t < 10; t++) begin
      in_valid = 1'b1; in_vector = tbl[t].vec; in_mode = tbl[t].mode;
      @(posedge clk); #1;
      in_valid = 1'b0; in_vector = $urandom; in_mode = 2'($urandom);
      chk($sformatf("tbl%0d_valid", t), 32'(out_valid1), 32'd1);
      chk($sformatf("tbl%0d_e1", t), 32'(out_vector1), 32'(tbl[t].exp1));
      chk($sformatf("tbl%0d_e4", t), 32'(out_vector4), 32'(tbl[t].exp4));
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_drain", t), 32'(out_valid1), 32'd0);
    end

    // Backpressure: fill to 2, third word held off.
    out_ready = 1'b0; in_valid = 1'b1; in_mode = 2'd0; in_vector = 8'h11;
    @(posedge clk); #1;
    chk("bp_ready_c1", 32'(in_ready1), 32'd1);
    in_vector = 8'h22;
    @(posedge clk); #1;
    chk("bp_ready_c2", 32'(in_ready1), 32'd0);
    chk("bp_head_c2", 32'(out_vector1), 32'h11);
    in_vector = 8'h33;
    @(posedge clk); #1;
    chk("bp_ready_hold", 32'(in_ready1), 32'd0);
    chk("bp_head_hold", 32'(out_vector1), 32'h11);
    chk("bp_valid_hold", 32'(out_valid1), 32'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_second", 32'(out_vector1), 32'h22);
    chk("bp_ready_rise", 32'(in_ready1), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_third", 32'(out_vector1), 32'h33);
    chk("bp_third_valid", 32'(out_valid1), 32'd1);
    @(posedge clk); #1;
    chk("bp_empty", 32'(out_valid1), 32'd0);

    // Streaming at count 1 with simultaneous push/pop.
    out_ready = 1'b0; in_valid = 1'b1; in_vector = $urandom; in_mode = 2'($urandom);
    tick();
    out_ready = 1'b1;
    for (int s = 0; s < 100; s++) begin
      in_vector = $urandom; in_mode = 2'($urandom);
      chk("stream_cnt_le1", 32'(in_ready1), 32'd1);
      tick();
    end
    in_valid = 1'b0;
    tick();

    // Random valid/ready patterns.
    for (int s = 0; s < 300; s++) begin
      in_valid = 1'($urandom); out_ready = 1'($urandom);
      in_vector = $urandom; in_mode = 2'($urandom);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) tick();

    // Reset mid-transfer with two words buffered.
    out_ready = 1'b0; in_valid = 1'b1;
    in_vector = 8'hC3; in_mode = 2'd0; tick();
    in_vector = 8'h96; tick();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid1), 32'd0);
    chk("midrst_in_ready", 32'(in_ready1), 32'd0);
    chk("midrst_out_vector1", 32'(out_vector1), 32'd0);
    chk("midrst_out_vector4", 32'(out_vector4), 32'd0);
    q1.delete(); q4.delete(); mrdy = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    mrdy = 1'b1;
    chk("postrst_in_ready", 32'(in_ready1), 32'd1);
    chk("postrst_out_valid", 32'(out_valid1), 32'd0);
    out_ready = 1'b1; in_valid = 1'b1; in_vector = 8'h5C; in_mode = 2'd1;
    tick();
    in_valid = 1'b0;
    chk("postrst_data", 32'(out_vector1), 32'h3A);
    tick();
    tick();

`ifdef VECTOR_REVERSE_XFER_COUNT_EN
    rst = 1'b1; #1; rst = 1'b0;
    q1.delete(); q4.delete();
    chk("xfer_rst", 32'(xc1), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b1; out_ready = 1'b1; in_vector = 8'h01; in_mode = 2'd0;
    @(posedge clk); #1;
    repeat (65537) @(posedge clk);
    #1;
    in_valid = 1'b0; out_ready = 1'b0;
    chk("xfer_wrap1", 32'(xc1), 32'd1);
    chk("xfer_wrap4", 32'(xc4), 32'd1);
    rst = 1'b1; #1;
    chk("xfer_clear", 32'(xc1), 32'd0);
    rst = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vector_reverse_pipe.md
VECTOR_REVERSE_PIPE -- requirements
Module: vector_reverse_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning vector width in bits.
REQ-002 SHALL have parameter ELEM, default 1, meaning element width in bits; WIDTH SHALL be an integer multiple of ELEM, N = WIDTH/ELEM elements.
REQ-003 SHALL have port clk, input, 1 bit: sole clock, all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: input word present.
REQ-006 SHALL have port in_ready, output, 1 bit: block can accept a word.
REQ-007 SHALL have port in_vector, input, WIDTH bits: input data.
REQ-008 SHALL have port in_mode, input, 2 bits: transform selected per word.
REQ-009 SHALL have port out_valid, output, 1 bit: output word present.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts word.
REQ-011 SHALL have port out_vector, output, WIDTH bits: transformed data.

Function
REQ-012 SHALL apply the transform on acceptance (in_valid && in_ready) and store the result; the mode is not stored.
REQ-013 SHALL pass the word unchanged for mode 00.
REQ-014 SHALL use mode 01 for element reverse: element k of output = element N-1-k of input; bit order inside elements is kept.
REQ-015 SHALL use mode 10 for intra-element reverse: bit j of each element becomes bit ELEM-1-j of the same element.
REQ-016 SHALL use mode 11 for full bit reverse: out bit i = in bit WIDTH-1-i, independent of ELEM.
REQ-017 SHALL buffer transformed words in a 2-entry FIFO, count 0..2, with a registered count.
REQ-018 SHALL drive in_ready = (count < 2), derived from registered state only, with no combinational path from out_ready.
REQ-019 SHALL drive out_valid = (count > 0), with out_vector equal to the head entry; out_vector SHALL hold while out_valid && !out_ready.
REQ-020 SHALL have latency 1: a word accepted at edge E into an empty buffer SHALL be presented with out_valid=1 immediately after E.
REQ-021 SHALL pop the head on out_valid && out_ready.
REQ-022 SHALL handle simultaneous push and pop at count 1 so that count stays 1 and the new word becomes head at the next edge.
REQ-023 SHALL NOT accept a push at count 2; a pop at count 2 SHALL give count 1, with in_ready rising the following cycle.
REQ-024 SHALL deliver words in acceptance order with none lost or duplicated under any valid/ready pattern.
REQ-025 SHALL leave the FIFO unchanged and ignore the data inputs when in_valid=0.

Reset
REQ-026 SHALL, while rst=1 and independent of clk, force count=0, out_valid=0, in_ready=0 and out_vector=0.
REQ-027 SHALL drive in_ready=1 from the first rising clk edge after rst deasserts.
REQ-028 SHALL discard buffered words on assertion of rst mid-transfer; no word accepted before reset SHALL appear afterwards.

Configuration
REQ-029 SHALL, with macro VECTOR_REVERSE_XFER_COUNT_EN defined, add output xfer_count, 16 bits, counting output transfers (out_valid && out_ready).
REQ-030 SHALL reset xfer_count to 0 asynchronously with rst and wrap it from 0xFFFF to 0x0000.
REQ-031 SHALL, without VECTOR_REVERSE_XFER_COUNT_EN, omit the xfer_count port and counter logic, leaving all other behaviour identical.

Verification
REQ-032 SHALL cover: WIDTH=8, ELEM=1, mode 01, in 0x01 with out_ready=1 -> out 0x80, out_valid=1 the cycle after acceptance.
REQ-033 SHALL cover: WIDTH=8, ELEM=4, in 0x12 with modes 00/01/10/11 -> 0x12 / 0x21 / 0x84 / 0x48.
REQ-034 SHALL cover: out_ready=0, push 0x11, 0x22, 0x33 on consecutive cycles -> in_ready=0 after the 2nd push, 0x33 held off; raising out_ready yields 0x11, 0x22, then 0x33 after acceptance.
REQ-035 SHALL cover: count=1, push and pop in the same cycle, streaming 100 random words -> output order matches the transformed input, count never exceeds 1.
REQ-036 SHALL cover: 2 words buffered, assert rst between edges -> out_valid=0 immediately; after release the next output is only post-reset data.
REQ-037 SHALL cover: with VECTOR_REVERSE_XFER_COUNT_EN, 65537 transfers -> xfer_count=1; rst -> 0.
